// File: rtl/simple_mem_responder.sv
// Target-side responder for the wr_en/wr_done, rd_en/rd_done 1024-bit line interface.
// Backs requests with a DEPTH-line register file and programmable write/read latencies.
module simple_mem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          DEPTH      = 4,
    parameter int          WR_LATENCY = 4,
    parameter int          RD_LATENCY = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [31:0]   wr_addr,
    input  logic [1023:0] wr_buffer,
    output logic          wr_done,
    input  logic          rd_en,
    input  logic [31:0]   rd_addr,
    output logic [1023:0] rd_buffer,
    output logic          rd_done,
    output logic          busy,
    output logic          req_err,
    output logic [15:0]   wr_count,
    output logic [15:0]   rd_count,
    output logic [15:0]   err_count
);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LINE_W = 1024;

    typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, RESP} state_t;

    typedef struct packed {
        logic             ok;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    function automatic dec_t decode(input logic [31:0] addr);
        logic [31:0] offset;
        dec_t        d;
        offset = addr - BASE_ADDR;
        d.ok   = (offset[6:0] == 7'd0) && (offset[31:7] < 25'(DEPTH));
        d.idx  = offset[7 +: IDX_W];
        return d;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t            state, state_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic              req_wr;
    dec_t              req_dec;
    logic [LINE_W-1:0] req_data;
    logic [LINE_W-1:0] mem [DEPTH];
    dec_t              in_dec;
    logic              accept;
    logic              resp_entry;

    // Write wins arbitration, so decode whichever address will be captured.
    assign in_dec     = decode(wr_en ? wr_addr : rd_addr);
    assign accept     = (state == IDLE) && (wr_en || rd_en);
    assign resp_entry = ((state == WR_BUSY) || (state == RD_BUSY)) && (cnt == 16'd0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    state_nxt = WR_BUSY;
                    cnt_nxt   = 16'(WR_LATENCY - 2);
                end else if (rd_en) begin
                    state_nxt = RD_BUSY;
                    cnt_nxt   = 16'(RD_LATENCY - 2);
                end
            end
            WR_BUSY, RD_BUSY: begin
                if (cnt == 16'd0) state_nxt = RESP;
                else              cnt_nxt   = cnt - 16'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_wr   <= 1'b0;
            req_dec  <= '0;
            req_data <= '0;
        end else if (accept) begin
            req_wr   <= wr_en;
            req_dec  <= in_dec;
            req_data <= wr_buffer;
        end
    end

    // Memory and read data update on the edge entering RESP; invalid writes leave memory alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (resp_entry && req_wr && req_dec.ok) begin
            mem[req_dec.idx] <= req_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_buffer <= '0;
        end else if (resp_entry && !req_wr) begin
            rd_buffer <= req_dec.ok ? mem[req_dec.idx] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count  <= 16'd0;
            rd_count  <= 16'd0;
            err_count <= 16'd0;
        end else if (state == RESP) begin
            if (req_wr) wr_count <= sat_inc(wr_count);
            else        rd_count <= sat_inc(rd_count);
            if (!req_dec.ok) err_count <= sat_inc(err_count);
        end
    end

    assign busy    = (state != IDLE);
    assign wr_done = (state == RESP) && req_wr;
    assign rd_done = (state == RESP) && !req_wr;
    assign req_err = (state == RESP) && !req_dec.ok;

endmodule

// File: tb/tb_simple_mem_responder.sv
// Randomized bench for simple_mem_responder against a line-level memory model.
module tb_simple_mem_responder;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 4;
    localparam int          WL    = 4;
    localparam int          RL    = 6;

    logic          clk, rst;
    logic          wr_en, rd_en;
    logic [31:0]   wr_addr, rd_addr;
    logic [1023:0] wr_buffer, rd_buffer;
    logic          wr_done, rd_done, busy, req_err;
    logic [15:0]   wr_count, rd_count, err_count;

    simple_mem_responder #(
        .BASE_ADDR(BASE), .DEPTH(DEPTH), .WR_LATENCY(WL), .RD_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_buffer(wr_buffer), .wr_done(wr_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_buffer(rd_buffer), .rd_done(rd_done),
        .busy(busy), .req_err(req_err),
        .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [1023:0] ref_mem [DEPTH];
    int            exp_wr, exp_rd, exp_err;

    task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        int w;
        checks++;
        if (got !== exp) begin
            w = 0;
            for (int i = 15; i >= 0; i--) if (got[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
            failures++;
            $display("FAIL %s: word%0d got=%h expected=%h", tag, w, got[w*64 +: 64], exp[w*64 +: 64]);
        end
    endtask

    // A line address is good when it sits on a 128-byte boundary inside the window.
    function automatic bit addr_ok(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off % 128 == 0) && (off / 128 < DEPTH);
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 128);
    endfunction

    task automatic rand_line(output logic [1023:0] d);
        for (int i = 0; i < 32; i++) d[i*32 +: 32] = $urandom();
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_wr_count"},  wr_count,  exp_wr);
        chk({tag, "_rd_count"},  rd_count,  exp_rd);
        chk({tag, "_err_count"}, err_count, exp_err);
    endtask

    // Starts at a negedge with the DUT idle; request is sampled at the next rising edge (e=0).
    // Done is expected in the cycle following edge e=LAT-1, so the initiator sees it at edge LAT.
    task automatic run_op(input bit wr, input logic [31:0] addr, input logic [1023:0] data);
        int            lat, done_at, pulses, other;
        bit            err_seen, busy_gap, ok;
        logic [1023:0] rb, exp_rb;
        int            idx;
        lat = wr ? WL : RL;
        done_at = -1; pulses = 0; other = 0; err_seen = 0; busy_gap = 0; rb = 'x;
        ok  = addr_ok(addr);
        idx = ok ? line_of(addr) : 0;
        if (wr) begin wr_en = 1'b1; wr_addr = addr; wr_buffer = data; end
        else    begin rd_en = 1'b1; rd_addr = addr; end
        for (int e = 0; e <= lat; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (wr ? wr_done : rd_done) begin
                pulses++;
                if (done_at < 0) done_at = e;
                err_seen = req_err;
                rb = rd_buffer;
                if (wr) wr_en = 1'b0; else rd_en = 1'b0;
            end
            if (wr ? rd_done : wr_done) other++;
            if (e < lat && !busy) busy_gap = 1'b1;
        end
        if (wr) wr_en = 1'b0; else rd_en = 1'b0;
        chk("done_edge", done_at, lat - 1);
        chk("done_pulses", pulses, 1);
        chk("other_done", other, 0);
        chk("req_err", err_seen, !ok);
        chk("busy_during", busy_gap, 0);
        chk("busy_after", busy, 0);
        if (wr) begin
            exp_wr++;
            if (ok) ref_mem[idx] = data;
        end else begin
            exp_rd++;
            exp_rb = ok ? ref_mem[idx] : '0;
            chk("rd_data", rb, exp_rb);
            chk("rd_held", rd_buffer, exp_rb);
        end
        if (!ok) exp_err++;
        check_counts(wr ? "wr" : "rd");
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_wr = 0; exp_rd = 0; exp_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] d;
        logic [31:0]   a;
        int            bad_done, bad_busy, ndone, sel, n_rd;
        bit            wr;

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_buffer = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_rd_done", rd_done, 0);
        chk("rst_req_err", req_err, 0);
        chk("rst_rd_buffer", rd_buffer, '0);
        check_counts("rst");
        rst = 1'b0;
        @(negedge clk);

        // Distinct DEAD pattern per 128-bit slice, write then read after a gap.
        for (int s = 0; s < 8; s++) d[s*128 +: 128] = {96'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD, 32'(s)};
        run_op(1'b1, BASE, d);
        repeat (10) @(negedge clk);
        run_op(1'b0, BASE, '0);

        // Fill all lines then read back in reverse order.
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 32; s++) d[s*32 +: 32] = 32'hA500_0000 | 32'(i);
            run_op(1'b1, BASE + 32'(128 * i), d);
        end
        for (int i = DEPTH - 1; i >= 0; i--) run_op(1'b0, BASE + 32'(128 * i), '0);

        // Decode errors: out of range, misaligned, below base.
        rand_line(d);
        run_op(1'b1, 32'h1000_0200, d);
        run_op(1'b1, 32'h1000_0004, d);
        run_op(1'b0, BASE, '0);
        run_op(1'b0, 32'h0FFF_FF80, '0);

        // Simultaneous write and read to line 1: write first, read follows with the new data.
        rand_line(d);
        rd_en = 1'b1; rd_addr = BASE + 32'h80;
        run_op(1'b1, BASE + 32'h80, d);
        run_op(1'b0, BASE + 32'h80, '0);

        // Held write request: one write per WL+1 cycles, busy drops for one cycle each time.
        rand_line(d);
        wr_en = 1'b1; wr_addr = BASE + 32'h100; wr_buffer = d;
        bad_done = 0; bad_busy = 0; ndone = 0;
        for (int e = 0; e < 3 * (WL + 1); e++) begin
            @(posedge clk);
            @(negedge clk);
            if (wr_done !== ((e % (WL + 1)) == WL - 1)) bad_done++;
            if (busy !== ((e % (WL + 1)) != WL)) bad_busy++;
            if (wr_done) ndone++;
        end
        wr_en = 1'b0;
        chk("hold_done_pattern", bad_done, 0);
        chk("hold_busy_pattern", bad_busy, 0);
        chk("hold_done_count", ndone, 3);
        ref_mem[2] = d;
        exp_wr += 3;
        check_counts("hold");
        run_op(1'b0, BASE + 32'h100, '0);

        // Reset in the middle of a read.
        rd_en = 1'b1; rd_addr = BASE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd_done", rd_done, 0);
        model_reset();
        check_counts("mid_rst");
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_rd = 0;
        repeat (RL + 2) begin
            @(negedge clk);
            if (rd_done) n_rd++;
        end
        chk("rst_no_rd_done", n_rd, 0);
        chk("rst_rd_buffer2", rd_buffer, '0);
        run_op(1'b0, BASE, '0);
        run_op(1'b0, BASE + 32'h180, '0);
        rand_line(d);
        run_op(1'b1, BASE + 32'h180, d);
        run_op(1'b0, BASE + 32'h180, '0);

        // Random mix of valid and invalid transactions.
        for (int n = 0; n < 40; n++) begin
            wr  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = BASE + 32'(128 * $urandom_range(0, DEPTH - 1));
            else if (sel == 7) a = BASE + 32'(128 * $urandom_range(DEPTH, DEPTH + 8));
            else if (sel == 8) a = BASE + 32'(128 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 127));
            else               a = BASE - 32'(128 * $urandom_range(1, 4));
            rand_line(d);
            run_op(wr, a, d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
